// File: rtl/run_stop_counter_if.sv
// run_stop_counter_if: control and status bundle for run_stop_counter.
// The master drives the requests and mode bits; the slave returns count and status.
`default_nettype none

interface run_stop_counter_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             clear;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic             up_down;
   logic             one_shot;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             done;
   logic             tc;

   modport master (
      output start, stop, clear, load_en, load_val, up_down, one_shot,
      input  count, running, done, tc
   );

   modport slave (
      input  start, stop, clear, load_en, load_val, up_down, one_shot,
      output count, running, done, tc
   );
endinterface

`default_nettype wire

// File: rtl/run_stop_counter.sv
// run_stop_counter: run/stop modulo counter with synchronised start/stop edges,
// up/down, wrap or one-shot, pause/resume, saturating load, clear and terminal pulse.
`default_nettype none

module run_stop_counter #(
   parameter int WIDTH       = 4,
   parameter int MAX_COUNT   = 13,
   parameter int SYNC_STAGES = 2
) (
   input wire                  clk,
   input wire                  reset,
   run_stop_counter_if.slave   bus
);

   generate
      if ((MAX_COUNT < 1) || (MAX_COUNT > (2**WIDTH) - 1)) begin : g_bad_max_count
         $error("run_stop_counter: MAX_COUNT out of range 1 .. 2**WIDTH-1");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("run_stop_counter: SYNC_STAGES must be at least 2");
      end
   endgenerate

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WIDTH-1:0]       r_count;
   logic [WIDTH-1:0]       w_count_nxt;
   logic                   r_tc;
   logic                   w_tc_nxt;

   logic [SYNC_STAGES-1:0] r_start_sync;
   logic [SYNC_STAGES-1:0] r_stop_sync;
   logic                   r_start_q;
   logic                   r_stop_q;
   logic                   w_start_p;
   logic                   w_stop_p;

   logic [WIDTH-1:0]       w_init;
   logic [WIDTH-1:0]       w_term;
   logic [WIDTH-1:0]       w_step;
   logic [WIDTH-1:0]       w_load_sat;

   // Button-style inputs: synchronise, then fire once per rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_start_sync <= '0;
         r_stop_sync  <= '0;
         r_start_q    <= 1'b0;
         r_stop_q     <= 1'b0;
      end else begin
         r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], bus.start};
         r_stop_sync  <= {r_stop_sync[SYNC_STAGES-2:0], bus.stop};
         r_start_q    <= r_start_sync[SYNC_STAGES-1];
         r_stop_q     <= r_stop_sync[SYNC_STAGES-1];
      end
   end

   assign w_start_p = r_start_sync[SYNC_STAGES-1] & ~r_start_q;
   assign w_stop_p  = r_stop_sync[SYNC_STAGES-1] & ~r_stop_q;

   assign w_init     = bus.up_down ? '0 : c_MAX;
   assign w_term     = bus.up_down ? c_MAX : '0;
   assign w_load_sat = (bus.load_val > c_MAX) ? c_MAX : bus.load_val;
   assign w_step     = bus.up_down
                     ? ((r_count >= c_MAX) ? '0 : r_count + WIDTH'(1))
                     : ((r_count == '0)    ? c_MAX : r_count - WIDTH'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_tc    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      if (bus.clear) begin
         w_state_nxt = IDLE;
         w_count_nxt = w_init;
      end else if (bus.load_en) begin
         w_count_nxt = w_load_sat;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_p) begin
                  w_state_nxt = RUN;
                  w_count_nxt = w_init;
               end
            end
            RUN: begin
               if (w_stop_p) begin
                  w_state_nxt = PAUSE;
               end else begin
                  w_count_nxt = w_step;
                  // tc is registered, so it lines up with the cycle count sits on terminal.
                  if (w_step == w_term) begin
                     w_tc_nxt = 1'b1;
                     if (bus.one_shot) begin
                        w_state_nxt = DONE;
                     end
                  end
               end
            end
            PAUSE: begin
               if (w_start_p) begin
                  w_state_nxt = RUN;
               end else if (w_stop_p) begin
                  w_state_nxt = IDLE;
               end
            end
            DONE: begin
               if (w_start_p) begin
                  w_state_nxt = RUN;
                  w_count_nxt = w_init;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign bus.count   = r_count;
   assign bus.running = (r_state == RUN);
   assign bus.done    = (r_state == DONE);
   assign bus.tc      = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_run_stop_counter.sv
// tb_run_stop_counter: directed, hand-computed checks of run_stop_counter
// (WIDTH=4, MAX_COUNT=13, SYNC_STAGES=2).
`default_nettype none

module tb_run_stop_counter;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   run_stop_counter_if #(.WIDTH(4)) bus ();

   run_stop_counter #(
      .WIDTH       (4),
      .MAX_COUNT   (13),
      .SYNC_STAGES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input int run, input int dn, input int t);
      chk({tag, ".count"},   int'(bus.count),   cnt);
      chk({tag, ".running"}, int'(bus.running), run);
      chk({tag, ".done"},    int'(bus.done),    dn);
      chk({tag, ".tc"},      int'(bus.tc),      t);
   endtask

   // Rising edge sampled at edge 0; state acts at edge 2; returns just after edge 2.
   task automatic pulse_start();
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(2);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.clear    = 1'b0;
      bus.load_en  = 1'b0;
      bus.load_val = '0;
      bus.up_down  = 1'b1;
      bus.one_shot = 1'b0;

      tick(2);
      chk_state("reset", 0, 0, 0, 0);
      reset = 1'b1;
      tick(2);

      // 1: up, wrap, start held high
      bus.start = 1'b1;
      tick(1);
      chk("t1_edge0_running", int'(bus.running), 0);
      tick(1);
      chk("t1_edge1_running", int'(bus.running), 0);
      tick(1);
      chk_state("t1_edge2", 0, 1, 0, 0);
      tick(1);
      chk("t1_edge3_count", int'(bus.count), 1);
      tick(11);
      chk_state("t1_pre_term", 12, 1, 0, 0);
      tick(1);
      chk_state("t1_term", 13, 1, 0, 1);
      tick(1);
      chk_state("t1_wrap", 0, 1, 0, 0);
      tick(1);
      chk_state("t1_after_wrap", 1, 1, 0, 0);
      bus.start = 1'b0;
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      chk_state("t1_clear", 0, 0, 0, 0);
      tick(3);

      // 2: up, one-shot
      bus.one_shot = 1'b1;
      pulse_start();
      chk_state("t2_start", 0, 1, 0, 0);
      tick(13);
      chk_state("t2_done", 13, 0, 1, 1);
      tick(1);
      chk_state("t2_done_hold1", 13, 0, 1, 0);
      tick(20);
      chk_state("t2_done_hold20", 13, 0, 1, 0);
      pulse_start();
      chk_state("t2_restart", 0, 1, 0, 0);
      bus.one_shot = 1'b0;
      bus.up_down  = 1'b0;
      bus.clear    = 1'b1;
      tick(1);
      bus.clear = 1'b0;

      // 3: down, wrap
      chk_state("t3_clear_init", 13, 0, 0, 0);
      tick(3);
      pulse_start();
      chk_state("t3_start", 13, 1, 0, 0);
      tick(1);
      chk("t3_first_step", int'(bus.count), 12);
      tick(12);
      chk_state("t3_term", 0, 1, 0, 1);
      tick(1);
      chk_state("t3_wrap", 13, 1, 0, 0);
      bus.up_down = 1'b1;
      bus.clear   = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      chk_state("t3_clear_up", 0, 0, 0, 0);
      tick(3);

      // 4: pause / resume / stop to idle / simultaneous start+stop
      pulse_start();
      tick(5);
      chk("t4_count5", int'(bus.count), 5);
      bus.stop = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      chk("t4_stop_e0", int'(bus.count), 6);
      tick(1);
      chk_state("t4_stop_e1", 7, 1, 0, 0);
      tick(1);
      chk_state("t4_paused", 7, 0, 0, 0);
      tick(5);
      chk_state("t4_pause_hold", 7, 0, 0, 0);
      pulse_start();
      chk_state("t4_resume", 7, 1, 0, 0);
      tick(1);
      chk("t4_resume_step", int'(bus.count), 8);
      bus.stop = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      tick(2);
      chk_state("t4_pause2", 10, 0, 0, 0);
      bus.stop = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      tick(2);
      chk_state("t4_idle_retained", 10, 0, 0, 0);
      tick(2);
      pulse_start();
      chk_state("t4_idle_reload", 0, 1, 0, 0);
      bus.stop = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      tick(2);
      chk_state("t4_pause3", 2, 0, 0, 0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick(1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      tick(2);
      chk_state("t4_both_resume", 2, 1, 0, 0);
      tick(1);
      chk("t4_both_step", int'(bus.count), 3);

      // 5: saturating load, clear mid-run, async reset mid-run
      bus.load_en  = 1'b1;
      bus.load_val = 4'd15;
      tick(1);
      bus.load_en = 1'b0;
      chk_state("t5_load_sat", 13, 1, 0, 0);
      tick(1);
      chk_state("t5_after_load", 0, 1, 0, 0);
      tick(3);
      chk("t5_run3", int'(bus.count), 3);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      chk_state("t5_clear_run", 0, 0, 0, 0);
      tick(3);
      pulse_start();
      tick(4);
      chk_state("t5_pre_reset", 4, 1, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk_state("t5_async_reset", 0, 0, 0, 0);
      tick(1);
      reset = 1'b1;
      tick(3);
      chk_state("t5_release", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
